// File: rtl/ifmon_pkg.sv
// ifmon_pkg: shared types, widths and helpers for the instruction-fetch pattern monitor
//   ch_state_e  : per-channel state (IDLE, COUNTING, ALERT)
//   clog2_min1  : ceil(log2(n)) clamped to at least 1 bit
//   WIN_W/CH_W  : widths for the default WINDOW/NUM_CH; modules recompute from their own parameters
package ifmon_pkg;
    typedef enum logic [1:0] {IDLE, COUNTING, ALERT} ch_state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_WINDOW = 64;
    localparam int WIN_W      = clog2_min1(DEF_WINDOW);
    localparam int CH_W       = clog2_min1(DEF_NUM_CH);
    localparam int HIT_TOT_W  = 16;
endpackage

// File: rtl/ifmon_channel.sv
// ifmon_channel: one mask/match pattern channel with windowed hit counting
//   clk_i, rst_i (async, active-low)
//   valid, inst          : fetch response
//   cfg_we               : load en/match/mask/thresh (already decoded for this channel)
//   clr                  : global clear, forces IDLE
//   hit                  : this fetch matches the channel pattern (independent of state)
//   alert_set            : channel enters ALERT at the next edge
module ifmon_channel
    import ifmon_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8,
    parameter int WINDOW = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid,
    input  logic [DATA_W-1:0] inst,
    input  logic              cfg_we,
    input  logic              cfg_en,
    input  logic [DATA_W-1:0] cfg_match,
    input  logic [DATA_W-1:0] cfg_mask,
    input  logic [CNT_W-1:0]  cfg_thresh,
    input  logic              clr,
    output logic              hit,
    output logic              alert_set
);
    localparam int WIN_BITS = clog2_min1(WINDOW);

    logic                en;
    logic [DATA_W-1:0]   match;
    logic [DATA_W-1:0]   mask;
    logic [CNT_W-1:0]    thresh;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_inc;
    logic [CNT_W-1:0]    thr_eff;
    logic [WIN_BITS-1:0] win;
    logic                drop;
    logic                expire;
    ch_state_e           state;

    assign hit     = valid & en & (((inst ^ match) & mask) == '0);
    // a clear or a config write to this channel discards any same-cycle hit
    assign drop    = clr | cfg_we;
    assign thr_eff = (thresh == '0) ? CNT_W'(1) : thresh;
    assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
    assign expire  = win == WIN_BITS'(WINDOW - 1);
    assign alert_set = hit & ~drop & ((state == IDLE && thr_eff == CNT_W'(1)) ||
                                      (state == COUNTING && cnt_inc >= thr_eff));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            en     <= 1'b0;
            match  <= '0;
            mask   <= '0;
            thresh <= '0;
            state  <= IDLE;
            cnt    <= '0;
            win    <= '0;
        end else begin
            if (cfg_we) begin
                en     <= cfg_en;
                match  <= cfg_match;
                mask   <= cfg_mask;
                thresh <= cfg_thresh;
            end
            if (drop) begin
                state <= IDLE;
                cnt   <= '0;
                win   <= '0;
            end else if (alert_set) begin
                state <= ALERT;
                cnt   <= cnt_inc;
            end else if (state == IDLE) begin
                if (hit) begin
                    state <= COUNTING;
                    cnt   <= CNT_W'(1);
                    win   <= '0;
                end
            end else if (state == COUNTING) begin
                if (expire) begin
                    // a hit on the expiry cycle opens a fresh window
                    state <= hit ? COUNTING : IDLE;
                    cnt   <= hit ? CNT_W'(1) : '0;
                    win   <= '0;
                end else begin
                    cnt <= hit ? cnt_inc : cnt;
                    win <= win + WIN_BITS'(1);
                end
            end
        end
    end
endmodule

// File: rtl/ifetch_pattern_monitor.sv
// ifetch_pattern_monitor: multi-channel mask/match monitor on the instruction-fetch response path
//   clk_i, rst_i (async, active-low)
//   mem_i_valid_i/inst_i/pc_i : fetch response being observed
//   cfg_we_i, cfg_ch_i, cfg_en_i, cfg_match_i, cfg_mask_i, cfg_thresh_i : channel config write
//   alert_clr_i  : clear sticky alert and all channel counts
//   alert_o, alert_ch_o, alert_pc_o : sticky alert with first-raising channel and PC
//   hit_total_o  : saturating count of fetches matching any channel
module ifetch_pattern_monitor
    import ifmon_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int WINDOW = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          mem_i_valid_i,
    input  logic [DATA_W-1:0]             mem_i_inst_i,
    input  logic [ADDR_W-1:0]             mem_i_pc_i,
    input  logic                          cfg_we_i,
    input  logic [clog2_min1(NUM_CH)-1:0] cfg_ch_i,
    input  logic                          cfg_en_i,
    input  logic [DATA_W-1:0]             cfg_match_i,
    input  logic [DATA_W-1:0]             cfg_mask_i,
    input  logic [CNT_W-1:0]              cfg_thresh_i,
    input  logic                          alert_clr_i,
    output logic                          alert_o,
    output logic [clog2_min1(NUM_CH)-1:0] alert_ch_o,
    output logic [ADDR_W-1:0]             alert_pc_o,
    output logic [HIT_TOT_W-1:0]          hit_total_o
);
    localparam int CH_BITS = clog2_min1(NUM_CH);

    logic [NUM_CH-1:0]  hit;
    logic [NUM_CH-1:0]  alert_set;
    logic [CH_BITS-1:0] first;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ifmon_channel #(.DATA_W(DATA_W), .CNT_W(CNT_W), .WINDOW(WINDOW)) u_ch (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .valid      (mem_i_valid_i),
            .inst       (mem_i_inst_i),
            .cfg_we     (cfg_we_i && cfg_ch_i == CH_BITS'(c)),
            .cfg_en     (cfg_en_i),
            .cfg_match  (cfg_match_i),
            .cfg_mask   (cfg_mask_i),
            .cfg_thresh (cfg_thresh_i),
            .clr        (alert_clr_i),
            .hit        (hit[c]),
            .alert_set  (alert_set[c])
        );
    end

    // lowest channel index wins when several complete together
    always_comb begin
        first = '0;
        for (int i = NUM_CH - 1; i >= 0; i--)
            if (alert_set[i]) first = CH_BITS'(i);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            alert_o     <= 1'b0;
            alert_ch_o  <= '0;
            alert_pc_o  <= '0;
            hit_total_o <= '0;
        end else begin
            if (alert_clr_i) begin
                alert_o    <= 1'b0;
                alert_ch_o <= '0;
                alert_pc_o <= '0;
            end else if (!alert_o && |alert_set) begin
                alert_o    <= 1'b1;
                alert_ch_o <= first;
                alert_pc_o <= mem_i_pc_i;
            end
            if (|hit && !(&hit_total_o)) hit_total_o <= hit_total_o + HIT_TOT_W'(1);
        end
    end
endmodule

// File: tb/tb_ifetch_pattern_monitor.sv
// tb_ifetch_pattern_monitor: scoreboard bench with a behavioural model of the fetch pattern monitor
module tb_ifetch_pattern_monitor;
    localparam int NCH    = 3;
    localparam int WINDOW = 64;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        mem_i_valid_i = 1'b0;
    logic [31:0] mem_i_inst_i = '0;
    logic [31:0] mem_i_pc_i = '0;
    logic        cfg_we_i = 1'b0;
    logic [1:0]  cfg_ch_i = '0;
    logic        cfg_en_i = 1'b0;
    logic [31:0] cfg_match_i = '0;
    logic [31:0] cfg_mask_i = '0;
    logic [7:0]  cfg_thresh_i = '0;
    logic        alert_clr_i = 1'b0;
    logic        alert_o;
    logic [1:0]  alert_ch_o;
    logic [31:0] alert_pc_o;
    logic [15:0] hit_total_o;

    int checks = 0;
    int failures = 0;

    ifetch_pattern_monitor #(.DATA_W(32), .ADDR_W(32), .NUM_CH(NCH), .CNT_W(8), .WINDOW(WINDOW)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .mem_i_valid_i (mem_i_valid_i),
        .mem_i_inst_i  (mem_i_inst_i),
        .mem_i_pc_i    (mem_i_pc_i),
        .cfg_we_i      (cfg_we_i),
        .cfg_ch_i      (cfg_ch_i),
        .cfg_en_i      (cfg_en_i),
        .cfg_match_i   (cfg_match_i),
        .cfg_mask_i    (cfg_mask_i),
        .cfg_thresh_i  (cfg_thresh_i),
        .alert_clr_i   (alert_clr_i),
        .alert_o       (alert_o),
        .alert_ch_o    (alert_ch_o),
        .alert_pc_o    (alert_pc_o),
        .hit_total_o   (hit_total_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        a;
        logic [1:0]  ch;
        logic [31:0] pc;
        logic [15:0] tot;
    } exp_t;
    exp_t q[$];

    // model: a channel is idle, counting hits since the cycle of its first hit, or alerted
    bit          m_en[NCH];
    logic [31:0] m_match[NCH];
    logic [31:0] m_mask[NCH];
    int          m_thr[NCH];
    int          m_mode[NCH];
    int          m_start[NCH];
    int          m_cnt[NCH];
    bit          m_alert;
    int          m_ach;
    logic [31:0] m_apc;
    int          m_tot;
    int          cyc = 0;

    logic [31:0] vals[4] = '{32'h12345678, 32'hCAFE0013, 32'h00B50533, 32'hDEAD8067};

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_en[i] = 0; m_match[i] = '0; m_mask[i] = '0; m_thr[i] = 0;
            m_mode[i] = 0; m_start[i] = 0; m_cnt[i] = 0;
        end
        m_alert = 0; m_ach = 0; m_apc = '0; m_tot = 0;
    endtask

    // advance the model by the cycle whose inputs are currently driven and queue the outcome
    task automatic model_step();
        bit h[NCH];
        bit any = 0;
        int first = -1;
        exp_t e;
        for (int i = 0; i < NCH; i++) begin
            h[i] = mem_i_valid_i && m_en[i] && (((mem_i_inst_i ^ m_match[i]) & m_mask[i]) == 0);
            any |= h[i];
        end
        for (int i = 0; i < NCH; i++) begin
            int thr;
            bit wr;
            thr = (m_thr[i] == 0) ? 1 : m_thr[i];
            wr = cfg_we_i && int'(cfg_ch_i) == i;
            if (alert_clr_i || wr) begin
                m_mode[i] = 0; m_cnt[i] = 0;
            end else if (m_mode[i] == 0) begin
                if (h[i]) begin
                    if (thr == 1) begin
                        m_mode[i] = 2;
                        if (first < 0) first = i;
                    end else begin
                        m_mode[i] = 1; m_start[i] = cyc; m_cnt[i] = 1;
                    end
                end
            end else if (m_mode[i] == 1) begin
                if (h[i]) begin
                    if (m_cnt[i] < 255) m_cnt[i]++;
                    if (m_cnt[i] >= thr) begin
                        m_mode[i] = 2;
                        if (first < 0) first = i;
                    end
                end
                if (m_mode[i] == 1 && cyc - m_start[i] == WINDOW) begin
                    if (h[i]) begin m_start[i] = cyc; m_cnt[i] = 1; end
                    else begin m_mode[i] = 0; m_cnt[i] = 0; end
                end
            end
            if (wr) begin
                m_en[i] = cfg_en_i; m_match[i] = cfg_match_i; m_mask[i] = cfg_mask_i; m_thr[i] = int'(cfg_thresh_i);
            end
        end
        if (alert_clr_i) begin
            m_alert = 0; m_ach = 0; m_apc = '0;
        end else if (!m_alert && first >= 0) begin
            m_alert = 1; m_ach = first; m_apc = mem_i_pc_i;
        end
        if (any && m_tot < 65535) m_tot++;
        cyc++;
        e.a = m_alert; e.ch = 2'(m_ach); e.pc = m_apc; e.tot = 16'(m_tot);
        q.push_back(e);
    endtask

    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc, input logic clr,
                        input logic we, input logic [1:0] ch, input logic en, input logic [31:0] mt,
                        input logic [31:0] mk, input logic [7:0] th);
        @(negedge clk);
        mem_i_valid_i = v; mem_i_inst_i = inst; mem_i_pc_i = pc; alert_clr_i = clr;
        cfg_we_i = we; cfg_ch_i = ch; cfg_en_i = en; cfg_match_i = mt; cfg_mask_i = mk; cfg_thresh_i = th;
        model_step();
    endtask

    task automatic fetch(input logic [31:0] inst, input logic [31:0] pc);
        step(1, inst, pc, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input logic [1:0] ch, input logic en, input logic [31:0] mt, input logic [31:0] mk, input logic [7:0] th);
        step(0, 0, 0, 0, 1, ch, en, mt, mk, th);
    endtask

    task automatic clear(input logic v, input logic [31:0] inst);
        step(v, inst, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    // reset pulse placed between edges so the outputs must drop with no clock
    task automatic pulse_reset();
        @(negedge clk);
        mem_i_valid_i = 0; alert_clr_i = 0; cfg_we_i = 0;
        #1 rst_i = 0;
        #1;
        chk("rst_alert_o", 32'(alert_o), 32'd0);
        chk("rst_alert_ch_o", 32'(alert_ch_o), 32'd0);
        chk("rst_alert_pc_o", alert_pc_o, 32'd0);
        chk("rst_hit_total_o", 32'(hit_total_o), 32'd0);
        rst_i = 1;
        model_reset();
        model_step();
    endtask

    function automatic logic [31:0] pick_inst();
        logic [31:0] v = vals[$urandom_range(0, 3)];
        return ($urandom_range(0, 3) == 0) ? v ^ ($urandom & 32'h0000_0F0F) : v;
    endfunction

    function automatic logic [31:0] pick_mask();
        int r = $urandom_range(0, 9);
        return (r < 5) ? 32'hFFFF_FFFF : (r < 8) ? 32'hFFFF_F0F0 : (r < 9) ? $urandom : 32'h0;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("alert_o", 32'(alert_o), 32'(e.a));
                chk("alert_ch_o", 32'(alert_ch_o), 32'(e.ch));
                chk("alert_pc_o", alert_pc_o, e.pc);
                chk("hit_total_o", 32'(hit_total_o), 32'(e.tot));
            end
        end
    end

    initial begin
        model_reset();
        #3;
        chk("reset_alert_o", 32'(alert_o), 32'd0);
        chk("reset_alert_ch_o", 32'(alert_ch_o), 32'd0);
        chk("reset_alert_pc_o", alert_pc_o, 32'd0);
        chk("reset_hit_total_o", 32'(hit_total_o), 32'd0);
        @(negedge clk);
        rst_i = 1;
        model_step();

        // single-hit threshold
        cfg(0, 1, 32'h12345678, 32'hFFFF_FFFF, 1);
        fetch(32'h12345678, 32'h40);
        idle(2);
        clear(0, 0);

        // threshold 3 inside the window, then a third hit past the window
        cfg(1, 1, vals[1], 32'hFFFF_FFFF, 3);
        fetch(vals[1], 32'h100); idle(9);
        fetch(vals[1], 32'h104); idle(9);
        fetch(vals[1], 32'h108); idle(3);
        clear(0, 0);
        fetch(vals[1], 32'h200); idle(9);
        fetch(vals[1], 32'h204); idle(59);
        fetch(vals[1], 32'h208); idle(2);
        fetch(vals[1], 32'h20C);
        fetch(vals[1], 32'h210); idle(2);

        // simultaneous completion on ch0 and ch2
        clear(0, 0);
        cfg(1, 0, 0, 0, 0);
        cfg(0, 1, vals[2], 32'hFFFF_FFFF, 1);
        cfg(2, 1, vals[2], 32'hFFFF_FFFF, 0);
        fetch(vals[2], 32'h80); idle(2);

        // clear wins over a same-cycle hit
        clear(0, 0);
        cfg(2, 0, 0, 0, 0);
        cfg(0, 1, vals[3], 32'hFFFF_FFFF, 2);
        fetch(vals[3], 32'h300);
        clear(1, vals[3]);
        fetch(vals[3], 32'h304); idle(2);
        fetch(vals[3], 32'h308); idle(2);
        clear(1, vals[3]); idle(2);

        // config write while counting, out-of-range channel, mask 0
        cfg(0, 0, 0, 0, 0);
        cfg(1, 1, vals[0], 32'hFFFF_FFFF, 3);
        fetch(vals[0], 32'h400);
        fetch(vals[0], 32'h404);
        cfg(1, 1, vals[0], 32'hFFFF_FFFF, 3);
        fetch(vals[0], 32'h408);
        fetch(vals[0], 32'h40C); idle(2);
        cfg(3, 1, 0, 0, 1);
        fetch(vals[0], 32'h410); idle(2);
        clear(0, 0);
        cfg(2, 1, 0, 0, 1);
        fetch(32'h0BAD_F00D, 32'h500); idle(2);

        // async reset during ALERT and during COUNTING
        pulse_reset();
        cfg(0, 1, vals[1], 32'hFFFF_FFFF, 5);
        fetch(vals[1], 32'h600); idle(3);
        pulse_reset();

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            int r;
            r = $urandom_range(0, 999);
            if (r < 4) pulse_reset();
            else if (r < 60) cfg(2'($urandom_range(0, 3)), 1'($urandom_range(0, 4) != 0), vals[$urandom_range(0, 3)],
                                 pick_mask(), 8'($urandom_range(0, 4)));
            else if (r < 75) step(1'($urandom_range(0, 1)), pick_inst(), $urandom, 1, 0, 0, 0, 0, 0, 0);
            else step(1'($urandom_range(0, 9) < 4), pick_inst(), $urandom, 0, 0, 0, 0, 0, 0, 0);
        end

        // drive the total counter into saturation
        clear(0, 0);
        cfg(0, 1, 0, 0, 1);
        for (int n = 0; n < 65535 + 300; n++) fetch($urandom, $urandom);
        idle(2);
        @(posedge clk);
        #2;
        chk("hit_total_saturated", 32'(hit_total_o), 32'h0000_FFFF);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
